// File: rtl/sram_arb.sv
// Two-to-one arbiter that shares one SRAM-like memory port between instruction fetch and data access.
// Only one transaction is in flight; the grant stays locked through the address handshake and the response.
module sram_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_I = 3'd1,
    ADDR_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  // Handshake: a master holds req until its addr_ok; addr_ok and data_ok are
  // single-cycle pulses combinational from bus_addr_ok / bus_data_ok.
  state_t state, state_nxt;
  logic   last_grant;
  logic   win_d;
  logic   sel_d;
  logic   grant_fire;
  logic   req_c;
  logic   inst_dok_c;
  logic   data_dok_c;

  // Round-robin favours the master that did not win last; last_grant resets to inst so data goes first.
  assign win_d = data_req & (~inst_req | (ARB_MODE == 0) | ~last_grant);

  always_comb begin
    state_nxt  = state;
    sel_d      = 1'b0;
    grant_fire = 1'b0;
    req_c      = 1'b0;
    inst_dok_c = 1'b0;
    data_dok_c = 1'b0;
    case (state)
      IDLE: begin
        sel_d = win_d;
        req_c = inst_req | data_req;
        if (inst_req | data_req) begin
          if (bus_addr_ok) begin
            grant_fire = 1'b1;
            state_nxt  = win_d ? RESP_D : RESP_I;
          end else begin
            state_nxt  = win_d ? ADDR_D : ADDR_I;
          end
        end
      end
      ADDR_I: begin
        req_c = inst_req;
        if (!inst_req) begin
          state_nxt = IDLE;
        end else if (bus_addr_ok) begin
          grant_fire = 1'b1;
          state_nxt  = RESP_I;
        end
      end
      ADDR_D: begin
        sel_d = 1'b1;
        req_c = data_req;
        if (!data_req) begin
          state_nxt = IDLE;
        end else if (bus_addr_ok) begin
          grant_fire = 1'b1;
          state_nxt  = RESP_D;
        end
      end
      RESP_I: begin
        if (bus_data_ok) begin
          inst_dok_c = 1'b1;
          state_nxt  = IDLE;
        end
      end
      RESP_D: begin
        sel_d = 1'b1;
        if (bus_data_ok) begin
          data_dok_c = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_fire) last_grant <= sel_d;
    end
  end

  // Gating with resetn keeps the handshake outputs quiet for the whole reset period.
  assign bus_req      = resetn & req_c;
  assign inst_addr_ok = resetn & grant_fire & ~sel_d;
  assign data_addr_ok = resetn & grant_fire & sel_d;
  assign inst_data_ok = resetn & inst_dok_c;
  assign data_data_ok = resetn & data_dok_c;

  assign bus_wr    = sel_d ? data_wr    : inst_wr;
  assign bus_size  = sel_d ? data_size  : inst_size;
  assign bus_addr  = sel_d ? data_addr  : inst_addr;
  assign bus_wdata = sel_d ? data_wdata : inst_wdata;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign dbg_state  = state;

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-to-one arbiter sharing the single SRAM-like memory port between the instruction-fetch and data-access requesters of the core. It sits between the pipeline's inst/data SRAM-like interfaces (the ones the pipeline control unit stalls on via addr_ok/data_ok) and the bus bridge. It keeps exactly one transaction outstanding, locks the grant until the address handshake and response complete, and selects the winner by fixed data priority or round-robin.

## Interface
- ARB_MODE, 0, 0 = fixed priority (data wins); 1 = round-robin between inst and data
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / data_req  in  1  request valid; held by master until its addr_ok
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  byte count code (0=1B, 1=2B, 2=4B)
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  address accepted for this master
- inst_data_ok / data_data_ok  out  1  response (read data valid / write done) for this master
- inst_rdata / data_rdata  out  32  read data, valid only with matching data_ok
- bus_req  out  1  request to memory port
- bus_wr, bus_size, bus_addr, bus_wdata  out  1/2/32/32  fields of granted master
- bus_rdata  in  32  read data from port
- bus_addr_ok  in  1  port accepted address
- bus_data_ok  in  1  port response

## Operation
- States: IDLE, ADDR_I, ADDR_D, RESP_I, RESP_D; plus 1-bit last_grant (0=inst, 1=data).
- IDLE: winner chosen combinationally. Only one requesting -> it wins. Both requesting -> ARB_MODE 0: data; ARB_MODE 1: the master not equal to last_grant. bus_req = inst_req | data_req; bus fields muxed from winner.
  - bus_addr_ok=1 -> winner's addr_ok=1 same cycle; next RESP_I/RESP_D; last_grant <= winner.
  - bus_addr_ok=0 and a winner exists -> next ADDR_I/ADDR_D (grant locked).
- ADDR_x: bus_req = owner's req; fields from owner only; other master never gets addr_ok.
  - owner req=1 and bus_addr_ok=1 -> owner addr_ok=1; next RESP_x; last_grant <= owner.
  - owner req=0 (cancelled, e.g. flush) -> bus_req=0; next IDLE; last_grant unchanged.
- RESP_x: bus_req=0, both addr_ok=0. bus_data_ok=1 -> owner data_ok=1, owner rdata=bus_rdata; next IDLE.
- inst_rdata and data_rdata are wired to bus_rdata; qualified solely by data_ok.
- data_ok is never asserted for the non-owner; bus_data_ok in IDLE or ADDR_x is ignored (no output, no state change).
- bus_addr_ok while bus_req=0 is ignored.

## Timing
- Reset (resetn=0, async): state=IDLE, last_grant=0; bus_req, both addr_ok, both data_ok forced 0 for the whole reset period regardless of inputs.
- addr_ok is combinational from bus_addr_ok: zero added latency on the address phase.
- data_ok is combinational from bus_data_ok in RESP_x: zero added latency on the response.
- One outstanding transaction: new request can be forwarded no earlier than the cycle after data_ok; minimum 2 cycles per transaction (addr cycle + response cycle with bus_data_ok=1 next cycle).
- Grant never switches while in ADDR_x or RESP_x, even if a higher-priority request appears.
- ARB_MODE 1 with both masters continuously requesting: grants strictly alternate starting with data after reset.
- Reset mid-transaction: state returns to IDLE immediately; a bus_data_ok arriving after reset release is dropped.

## Test plan
- Single inst read: inst_req=1, addr=0xBFC00000, bus_addr_ok=1 in cycle 0, bus_data_ok=1 with bus_rdata=0x3C1DBFC0 in cycle 1 -> inst_addr_ok=1 cycle 0, inst_data_ok=1 and inst_rdata=0x3C1DBFC0 cycle 1, data_data_ok stays 0.
- Contention, ARB_MODE 0: inst_req and data_req both 1 for 6 transactions, bus_addr_ok=1, bus_data_ok one cycle later -> all 6 grants to data; inst_addr_ok never 1 while data_req=1.
- Contention, ARB_MODE 1: same stimulus -> grant order data, inst, data, inst, data, inst.
- Lock under back-pressure: inst wins in IDLE, bus_addr_ok=0 for 3 cycles while data_req rises in cycle 1 -> bus_addr stays inst_addr, data_addr_ok=0; inst_addr_ok=1 on cycle bus_addr_ok first 1.
- Cancel: ADDR_D with bus_addr_ok=0, data_req drops -> bus_req=0 same cycle, IDLE next; pending inst_req then granted; stray bus_data_ok in IDLE produces no data_ok.
- Async reset in RESP_D: resetn low mid-cycle -> all ok outputs and bus_req 0 immediately; after release, bus_data_ok=1 yields no data_data_ok.
